// File: rtl/i2c_slave.sv
// I2C target: oversampled scl/sda with glitch filtering, fixed 7-bit address,
// byte hand-off to user logic on writes and byte fetch (tx_req/tx_data) on reads.

module i2c_slave_filt #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o
);
  logic       s1_q, s2_q, filt_q;
  logic [2:0] cnt_q;

  // Idle bus level is high, so the whole chain resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      if (s2_q == filt_q)
        cnt_q <= '0;
      else if (cnt_q == 3'(FILTER_LEN - 1)) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else
        cnt_q <= cnt_q + 3'd1;
    end
  end

  assign out_o = filt_q;
endmodule

module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5A,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       mack_q, mack_d;
  logic       scl_f, sda_f, scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_filt #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .in_i(scl), .out_o(scl_f)
  );
  i2c_slave_filt #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .in_i(sda), .out_o(sda_f)
  );

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req   = tx_req_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = sda_prev_q & ~sda_f & scl_f & scl_prev_q;
  assign stop_det  = ~sda_prev_q & sda_f & scl_f & scl_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    mack_d     = mack_q;

    if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
      mack_d   = 1'b0;
    end else if (start_det) begin
      // Covers both a fresh and a repeated START.
      state_d  = ADDR;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
      shift_d  = '0;
      mack_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'd0) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rw_q)
            tx_req_d = 1'b1;
          else if (scl_fall) begin
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = WR_DATA;
            end else begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              cnt_d    = 4'd1;
              state_d  = RD_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_f};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = WR_DATA;
          end
        end
        RD_DATA: begin
          // cnt counts bits already presented; shift_q[7] is the bit on the bus.
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_d = 1'b1;
              mack_d   = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end else if (scl_fall && mack_q) begin
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            cnt_d    = 4'd1;
            mack_d   = 1'b0;
            state_d  = RD_DATA;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Responder end of the team's I2C link. It is the target device that the existing I2C master addresses, and it sits on the same shared scl/sda pair inside the SoC sensor subsystem. It oversamples scl/sda on the system clock, decodes START/STOP, matches a fixed 7-bit address, ACKs writes and hands bytes to user logic. On reads it fetches bytes from user logic and shifts them out.

Parameters:
SLAVE_ADDR, 7'h5A, 7-bit bus address this block answers to.
FILTER_LEN, 3, consecutive identical samples required before a filtered scl/sda level changes (glitch filter, range 1-7).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
scl  input  1  I2C clock from master (slave never stretches).
sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
tx_data  input  8  byte to return on a read; sampled as defined below.
tx_req  output  1  one-clk pulse requesting the next read byte.
rx_data  output  8  last byte written by the master.
rx_valid  output  1  one-clk pulse when rx_data is updated.
rw  output  1  R/W bit of the current addressed transaction (1 = read).
busy  output  1  high while this slave is the addressed target.

Behaviour:
- Reset (async): sda released (z), rx_data=8'h00, rx_valid=0, tx_req=0, rw=0, busy=0, state IDLE, shift regs cleared. A reset mid-transfer releases sda immediately.
- Input path: 2-FF synchronizer on scl and sda, then a FILTER_LEN-sample filter. Edge latency from pin to decision is 2+FILTER_LEN clk. The master's scl high and low phases must each be ≥ 2*(FILTER_LEN+3) clk.
- START: filtered sda falls while filtered scl is high. STOP: filtered sda rises while filtered scl is high. Both take priority over bit processing.
- Data is sampled on filtered scl rising edges. The slave changes sda only on filtered scl falling edges, 1 clk after detection.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: on START -> ADDR, bit counter=0.
- ADDR: shift 8 bits MSB first.
  - On the 8th falling edge, if addr[7:1]==SLAVE_ADDR: drive sda low, latch rw=bit0, busy=1, -> ADDR_ACK.
  - Otherwise release sda -> IGNORE.
  - A general call (addr 0) is not acknowledged.
- ADDR_ACK: tx_req pulses at the ACK-bit rising edge when rw=1. At the next falling edge:
  - rw=0: release sda -> WR_DATA.
  - rw=1: load shift reg from tx_data, drive bit7 (0 -> low, 1 -> z) -> RD_DATA.
- WR_DATA: shift 8 bits. On the 8th falling edge: rx_data <= shifted byte, rx_valid pulses for 1 clk, drive ACK low -> WR_ACK. Every write byte is ACKed; no overflow condition.
- WR_ACK: at the next falling edge release sda -> WR_DATA.
- RD_DATA: present the next bit on each falling edge. After the 8th bit's falling edge, release sda -> RD_ACK.
- RD_ACK: sample the master's bit on the rising edge.
  - ACK (0): tx_req pulse at that rising edge; at the falling edge reload from tx_data -> RD_DATA.
  - NACK (1): busy=0 -> IGNORE, sda released.
- IGNORE: sda released; waits for START or STOP.
- Any state: STOP -> IDLE, busy=0, sda released. Repeated START -> ADDR, busy=0, sda released, counters cleared.
- tx_data timing: tx_data must be stable from the tx_req pulse to the following scl falling edge, which is ≥ half an scl period later.
- rx_valid and tx_req are never high in the same clk.
- Bus contention (sda read back differs from a driven 0) is not detected.

Test Plan:
- Write 7'h5A with data 8'hA6 then 8'h72, driven by the existing master at the shared clk: ACK on the address and both bytes. rx_valid pulses twice with rx_data=A6 then 72, rw=0, and the master's ack_error stays 0. busy falls after STOP.
- Address 7'h3C: no ACK (sda stays z on the 9th clock), master ack_error=1, busy stays 0, rx_valid never pulses.
- Read from 7'h5A with tx_data=8'hC3, master reads 2 bytes then NACKs: master data_rd=C3 both times. tx_req pulses twice, the slave releases sda after the NACK, and rw=1.
- Write A6 to 5A, then a repeated START with read from 5A: rw flips 0->1, tx_req pulses after the second address ACK, no STOP in between.
- Assert reset during bit 4 of a read byte whose bit is 0: sda releases to z within 1 clk. Outputs return to reset values, and the next START+5A is ACKed normally.
- Inject a 1-clk low glitch on scl while high and a 2-clk sda glitch (FILTER_LEN=3): no extra bit is shifted, no false START/STOP, and the transfer completes with correct data.
